// File: rtl/snake_position_store.sv
// Snake head/body position store: steps the snake one block per granted move_tick,
// serves registered body-segment reads to the renderer and flags self-collision.
module snake_position_store #(
   parameter int unsigned SNAKE_LENGTH_BIT = 4,
   parameter int unsigned GRID_W           = 80,
   parameter int unsigned GRID_H           = 60,
   parameter int unsigned INIT_X           = 40,
   parameter int unsigned INIT_Y           = 30
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic                        semaforo,
   input  logic                        move_tick,
   input  logic [1:0]                  direction,
   input  logic                        grow,
   input  logic [SNAKE_LENGTH_BIT-1:0] body_count,
   output logic [6:0]                  snake_head_x,
   output logic [6:0]                  snake_head_y,
   output logic [6:0]                  snake_body_x,
   output logic [6:0]                  snake_body_y,
   output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
   output logic                        busy,
   output logic                        update_done,
   output logic                        collision
);

   localparam int unsigned LW       = SNAKE_LENGTH_BIT;
   localparam int unsigned MAX_BODY = (1 << LW) - 1;
   localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BODY);
   localparam logic [6:0] EMPTY  = 7'h7F;
   localparam logic [6:0] X_MAX  = 7'(GRID_W - 1);
   localparam logic [6:0] Y_MAX  = 7'(GRID_H - 1);
   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_UP    = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   typedef enum logic [2:0] {IDLE, SHIFT, HEAD, CHECK, DONE} state_t;

   state_t          state_q, state_d;
   logic [6:0]      head_x_q, head_x_d, head_y_q, head_y_d;
   logic [6:0]      body_x_q [0:MAX_BODY];
   logic [6:0]      body_x_d [0:MAX_BODY];
   logic [6:0]      body_y_q [0:MAX_BODY];
   logic [6:0]      body_y_d [0:MAX_BODY];
   logic [6:0]      rd_x_q, rd_x_d, rd_y_q, rd_y_d;
   logic [1:0]      dir_q, dir_d;
   logic [LW-1:0]   len_q, len_d, len_n_q, len_n_d, idx_q, idx_d;
   logic            move_pend_q, move_pend_d, grow_pend_q, grow_pend_d;
   logic            busy_q, busy_d, done_q, done_d, col_q, col_d;

   logic            start_c;
   logic            grow_add_c;
   logic [LW-1:0]   len_n_c;

   assign start_c    = move_pend_q && semaforo && !col_q;
   assign grow_add_c = grow_pend_q && (len_q < MAX_LEN);
   assign len_n_c    = len_q + LW'(grow_add_c);

   // State register
   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start_c) state_d = (len_n_c == '0) ? HEAD : SHIFT;
         SHIFT: if (idx_q == '0) state_d = HEAD;
         HEAD:  state_d = (len_n_q == '0) ? DONE : CHECK;
         CHECK: if (idx_q == LW'(len_q - LW'(1))) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      head_x_d    = head_x_q;
      head_y_d    = head_y_q;
      body_x_d    = body_x_q;
      body_y_d    = body_y_q;
      dir_d       = dir_q;
      len_d       = len_q;
      len_n_d     = len_n_q;
      idx_d       = idx_q;
      move_pend_d = move_pend_q | move_tick;
      grow_pend_d = grow_pend_q | grow;
      busy_d      = busy_q;
      done_d      = 1'b0;
      col_d       = col_q;

      if (body_count < len_q) begin
         rd_x_d = body_x_q[body_count];
         rd_y_d = body_y_q[body_count];
      end else begin
         rd_x_d = EMPTY;
         rd_y_d = EMPTY;
      end

      case (state_q)
         IDLE: begin
            if (start_c) begin
               move_pend_d = move_tick;
               grow_pend_d = grow;
               busy_d      = 1'b1;
               len_n_d     = len_n_c;
               idx_d       = LW'(len_n_c - LW'(1));
               // A reversal would fold the snake onto itself, so it is ignored
               if (direction != (dir_q ^ 2'b10)) dir_d = direction;
            end
         end
         SHIFT: begin
            if (idx_q == '0) begin
               body_x_d[0] = head_x_q;
               body_y_d[0] = head_y_q;
            end else begin
               body_x_d[idx_q] = body_x_q[LW'(idx_q - LW'(1))];
               body_y_d[idx_q] = body_y_q[LW'(idx_q - LW'(1))];
               idx_d           = LW'(idx_q - LW'(1));
            end
         end
         HEAD: begin
            case (dir_q)
               DIR_RIGHT: head_x_d = (head_x_q == X_MAX) ? 7'd0 : 7'(head_x_q + 7'd1);
               DIR_UP:    head_y_d = (head_y_q == 7'd0) ? Y_MAX : 7'(head_y_q - 7'd1);
               DIR_LEFT:  head_x_d = (head_x_q == 7'd0) ? X_MAX : 7'(head_x_q - 7'd1);
               DIR_DOWN:  head_y_d = (head_y_q == Y_MAX) ? 7'd0 : 7'(head_y_q + 7'd1);
               default:   head_x_d = head_x_q;
            endcase
            len_d = len_n_q;
            idx_d = '0;
         end
         CHECK: begin
            if ((body_x_q[idx_q] == head_x_q) && (body_y_q[idx_q] == head_y_q)) col_d = 1'b1;
            idx_d = LW'(idx_q + LW'(1));
         end
         DONE: begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: busy_d = 1'b0;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         for (int k = 0; k <= int'(MAX_BODY); k++) begin
            body_x_q[k] <= EMPTY;
            body_y_q[k] <= EMPTY;
         end
         body_x_q[0] <= 7'(INIT_X - 1);
         body_y_q[0] <= 7'(INIT_Y);
         body_x_q[1] <= 7'(INIT_X - 2);
         body_y_q[1] <= 7'(INIT_Y);
         head_x_q    <= 7'(INIT_X);
         head_y_q    <= 7'(INIT_Y);
         rd_x_q      <= EMPTY;
         rd_y_q      <= EMPTY;
         dir_q       <= DIR_RIGHT;
         len_q       <= LW'(2);
         len_n_q     <= '0;
         idx_q       <= '0;
         move_pend_q <= 1'b0;
         grow_pend_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         col_q       <= 1'b0;
      end else begin
         body_x_q    <= body_x_d;
         body_y_q    <= body_y_d;
         head_x_q    <= head_x_d;
         head_y_q    <= head_y_d;
         rd_x_q      <= rd_x_d;
         rd_y_q      <= rd_y_d;
         dir_q       <= dir_d;
         len_q       <= len_d;
         len_n_q     <= len_n_d;
         idx_q       <= idx_d;
         move_pend_q <= move_pend_d;
         grow_pend_q <= grow_pend_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         col_q       <= col_d;
      end
   end

   assign snake_head_x = head_x_q;
   assign snake_head_y = head_y_q;
   assign snake_body_x = rd_x_q;
   assign snake_body_y = rd_y_q;
   assign snake_length = len_q;
   assign busy         = busy_q;
   assign update_done  = done_q;
   assign collision    = col_q;

endmodule

// File: tb/tb_snake_position_store.sv
// Scoreboard bench for snake_position_store: a grid model predicts each step and each body read.
module tb_snake_position_store;

   logic       clock_25 = 1'b0;
   logic       reset;
   logic       semaforo;
   logic       move_tick;
   logic [1:0] direction;
   logic       grow;
   logic [3:0] body_count;
   logic [6:0] snake_head_x, snake_head_y, snake_body_x, snake_body_y;
   logic [3:0] snake_length;
   logic       busy, update_done, collision;

   snake_position_store dut (
      .clock_25     (clock_25),
      .reset        (reset),
      .semaforo     (semaforo),
      .move_tick    (move_tick),
      .direction    (direction),
      .grow         (grow),
      .body_count   (body_count),
      .snake_head_x (snake_head_x),
      .snake_head_y (snake_head_y),
      .snake_body_x (snake_body_x),
      .snake_body_y (snake_body_y),
      .snake_length (snake_length),
      .busy         (busy),
      .update_done  (update_done),
      .collision    (collision)
   );

   always #5 clock_25 = ~clock_25;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model of the snake on the grid
   int m_x [16];
   int m_y [16];
   int m_hx, m_hy, m_len, m_dir;
   int m_col;

   task automatic model_reset();
      for (int k = 0; k < 16; k++) begin
         m_x[k] = 127;
         m_y[k] = 127;
      end
      m_x[0] = 39; m_y[0] = 30;
      m_x[1] = 38; m_y[1] = 30;
      m_hx = 40; m_hy = 30; m_len = 2; m_dir = 0; m_col = 0;
   endtask

   task automatic model_step(input int d, input bit g, output int len_n);
      if (d != (m_dir ^ 2)) m_dir = d;
      len_n = m_len + ((g && m_len < 15) ? 1 : 0);
      for (int k = len_n - 1; k > 0; k--) begin
         m_x[k] = m_x[k-1];
         m_y[k] = m_y[k-1];
      end
      m_x[0] = m_hx;
      m_y[0] = m_hy;
      case (m_dir)
         0: m_hx = (m_hx + 1) % 80;
         1: m_hy = (m_hy + 59) % 60;
         2: m_hx = (m_hx + 79) % 80;
         default: m_hy = (m_hy + 1) % 60;
      endcase
      m_len = len_n;
      for (int k = 0; k < m_len; k++)
         if (m_x[k] == m_hx && m_y[k] == m_hy) m_col = 1;
   endtask

   typedef struct { int hx; int hy; int len; int col; int lat; } step_exp_t;
   typedef struct { int x; int y; } rd_exp_t;
   step_exp_t step_q[$];
   rd_exp_t   rd_q[$];

   task automatic read_sweep(input int n);
      rd_exp_t e, r;
      for (int idx = 0; idx < n; idx++) begin
         @(negedge clock_25);
         body_count = 4'(idx);
         e.x = (idx < m_len) ? m_x[idx] : 127;
         e.y = (idx < m_len) ? m_y[idx] : 127;
         rd_q.push_back(e);
         @(posedge clock_25); #1;
         r = rd_q.pop_front();
         check($sformatf("body_x[%0d]", idx), int'(snake_body_x), r.x);
         check($sformatf("body_y[%0d]", idx), int'(snake_body_y), r.y);
      end
   endtask

   // Wait for update_done; cyc counts rising edges since the edge that latched the request
   task automatic wait_done(input string tag, input int start_cyc);
      step_exp_t e;
      int  cyc;
      bit  seen;
      cyc  = start_cyc;
      seen = 0;
      while (cyc < 80 && !seen) begin
         @(posedge clock_25); #1;
         cyc++;
         if (update_done) seen = 1;
      end
      e = step_q.pop_front();
      if (!seen) begin
         check({tag, "_timeout"}, 0, 1);
      end else begin
         check({tag, "_lat"},  cyc, e.lat);
         check({tag, "_hx"},   int'(snake_head_x), e.hx);
         check({tag, "_hy"},   int'(snake_head_y), e.hy);
         check({tag, "_len"},  int'(snake_length), e.len);
         check({tag, "_col"},  int'(collision), e.col);
         check({tag, "_busy"}, int'(busy), 0);
         @(posedge clock_25); #1;
         check({tag, "_pulse"}, int'(update_done), 0);
      end
   endtask

   task automatic do_step(input int d, input bit g, input string tag);
      step_exp_t e;
      int len_n;
      model_step(d, g, len_n);
      e = '{m_hx, m_hy, m_len, m_col, 2 * len_n + 4};
      step_q.push_back(e);
      @(negedge clock_25);
      direction = 2'(d);
      grow      = g;
      move_tick = 1'b1;
      semaforo  = 1'b1;
      @(posedge clock_25); #1;
      @(negedge clock_25);
      move_tick = 1'b0;
      grow      = 1'b0;
      @(posedge clock_25); #1;
      check({tag, "_busy_start"}, int'(busy), 1);
      wait_done(tag, 2);
   endtask

   initial begin
      step_exp_t e;
      int len_n, cyc;
      bit seen;

      reset = 1'b1; semaforo = 1'b0; move_tick = 1'b0; direction = 2'b00;
      grow = 1'b0; body_count = 4'd0;
      model_reset();
      repeat (3) @(posedge clock_25);
      #1;
      check("rst_hx",   int'(snake_head_x), 40);
      check("rst_hy",   int'(snake_head_y), 30);
      check("rst_len",  int'(snake_length), 2);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(update_done), 0);
      check("rst_col",  int'(collision), 0);
      check("rst_rdx",  int'(snake_body_x), 127);
      @(negedge clock_25); reset = 1'b0;
      read_sweep(4);

      // Request held off while the renderer is reading
      @(negedge clock_25); move_tick = 1'b1; semaforo = 1'b0;
      @(negedge clock_25); move_tick = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clock_25); #1;
         if (busy || update_done) seen = 1;
      end
      check("hold_busy", int'(seen), 0);
      model_step(0, 0, len_n);
      e = '{m_hx, m_hy, m_len, m_col, 7};
      step_q.push_back(e);
      @(negedge clock_25); semaforo = 1'b1;
      wait_done("first", 0);
      check("first_hx_const", int'(snake_head_x), 41);
      read_sweep(3);

      do_step(2, 0, "reverse");
      check("reverse_hx_const", int'(snake_head_x), 42);
      do_step(0, 1, "grow");
      check("grow_len_const", int'(snake_length), 3);
      read_sweep(4);

      while (m_hx != 79) do_step(0, 0, "walk_r");
      do_step(0, 0, "wrap_r");
      check("wrap_r_const", int'(snake_head_x), 0);
      repeat (5) do_step(0, 0, "walk_r2");
      while (m_hy != 0) do_step(1, 0, "walk_u");
      do_step(1, 0, "wrap_u");
      check("wrap_u_x_const", int'(snake_head_x), 5);
      check("wrap_u_y_const", int'(snake_head_y), 59);

      do_step(0, 1, "grow4");
      do_step(0, 0, "r_a");
      do_step(0, 0, "r_b");
      read_sweep(5);
      do_step(3, 0, "down");
      do_step(2, 0, "left");
      check("col_before", int'(collision), 0);
      do_step(1, 0, "up");
      check("col_after", int'(collision), 1);

      // Collision blocks all further steps
      @(negedge clock_25); move_tick = 1'b1; semaforo = 1'b1;
      @(negedge clock_25); move_tick = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clock_25); #1;
         if (busy || update_done) seen = 1;
      end
      check("blocked", int'(seen), 0);

      @(negedge clock_25); reset = 1'b1;
      #1;
      check("rst2_col", int'(collision), 0);
      check("rst2_hx",  int'(snake_head_x), 40);
      check("rst2_len", int'(snake_length), 2);
      @(negedge clock_25); reset = 1'b0;
      model_reset();
      read_sweep(3);

      // Reset in the middle of a step
      @(negedge clock_25); move_tick = 1'b1; direction = 2'b01;
      @(negedge clock_25); move_tick = 1'b0;
      repeat (3) @(posedge clock_25);
      @(negedge clock_25); reset = 1'b1;
      #1;
      check("mid_busy", int'(busy), 0);
      seen = 0;
      repeat (3) begin
         @(posedge clock_25); #1;
         if (update_done) seen = 1;
      end
      check("mid_no_done", int'(seen), 0);
      check("mid_hx", int'(snake_head_x), 40);
      check("mid_hy", int'(snake_head_y), 30);
      @(negedge clock_25); reset = 1'b0;
      cyc = 0;
      repeat (3) begin
         @(posedge clock_25); #1;
         if (busy) cyc++;
      end
      check("mid_idle", cyc, 0);
      do_step(0, 0, "recover");
      read_sweep(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
